// File: rtl/ped_request_ctrl.sv
// Pedestrian request stage: turns debounced button presses into a held walk
// request with req/ack/done handshake, post-walk lockout and a press counter.
module ped_request_ctrl #(
  parameter int unsigned LOCKOUT_CYCLES = 100,
  parameter int unsigned LCK_W          = 7,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn,
  input  logic             walk_ack,
  input  logic             walk_done,
  output logic             walk_req,
  output logic             pending,
  output logic             lockout,
  output logic             press_pulse,
  output logic [CNT_W-1:0] press_count,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVE   = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  localparam logic [LCK_W-1:0] LCK_LOAD = LCK_W'(LOCKOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state;
  state_t           state_nx;
  logic             btn_q;
  logic             deferred;
  logic             deferred_nx;
  logic [LCK_W-1:0] lck_cnt;
  logic [LCK_W-1:0] lck_cnt_nx;
  logic             rise_c;
  logic             accept_c;

  // btn_q resets high so a button held through reset is not seen as a press
  assign rise_c   = btn & ~btn_q;
  assign accept_c = rise_c & ((state == IDLE) | (state == LOCKOUT));

  assign state_dbg = state;

  // Next-state, deferred-request and lockout-counter decode
  always_comb begin
    state_nx    = state;
    deferred_nx = deferred;
    lck_cnt_nx  = lck_cnt;
    case (state)
      IDLE: begin
        if (rise_c) state_nx = REQ;
      end
      REQ: begin
        if (walk_ack) state_nx = SERVE;
      end
      SERVE: begin
        if (walk_done) begin
          state_nx   = LOCKOUT;
          lck_cnt_nx = LCK_LOAD;
        end
      end
      LOCKOUT: begin
        if (lck_cnt == '0) begin
          state_nx    = (deferred | rise_c) ? REQ : IDLE;
          deferred_nx = 1'b0;
        end else begin
          lck_cnt_nx = lck_cnt - LCK_W'(1);
          if (rise_c) deferred_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register with Moore outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      btn_q       <= 1'b1;
      deferred    <= 1'b0;
      lck_cnt     <= '0;
      walk_req    <= 1'b0;
      pending     <= 1'b0;
      lockout     <= 1'b0;
      press_pulse <= 1'b0;
      press_count <= '0;
    end else begin
      state       <= state_nx;
      btn_q       <= btn;
      deferred    <= deferred_nx;
      lck_cnt     <= lck_cnt_nx;
      walk_req    <= (state_nx == REQ);
      pending     <= (state_nx == REQ) | ((state_nx == LOCKOUT) & deferred_nx);
      lockout     <= (state_nx == LOCKOUT);
      press_pulse <= accept_c;
      if (accept_c && (press_count != CNT_MAX)) begin
        press_count <= press_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Directed bench for ped_request_ctrl with a 4-cycle lockout and 3-bit press counter.
module tb_ped_request_ctrl;

  localparam int unsigned LOCKOUT_CYCLES = 4;
  localparam int unsigned LCK_W          = 3;
  localparam int unsigned CNT_W          = 3;

  logic             clk;
  logic             rst_n;
  logic             btn;
  logic             walk_ack;
  logic             walk_done;
  logic             walk_req;
  logic             pending;
  logic             lockout;
  logic             press_pulse;
  logic [CNT_W-1:0] press_count;
  logic [1:0]       state_dbg;

  int total;
  int bad;

  ped_request_ctrl #(
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
    .LCK_W(LCK_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn(btn),
    .walk_ack(walk_ack),
    .walk_done(walk_done),
    .walk_req(walk_req),
    .pending(pending),
    .lockout(lockout),
    .press_pulse(press_pulse),
    .press_count(press_count),
    .state_dbg(state_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    btn       = 1'b1;
    walk_ack  = 1'b0;
    walk_done = 1'b0;

    // Reset values with button held
    tick(); tick();
    chk("rst_walk_req", 32'(walk_req), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_lockout", 32'(lockout), 0);
    chk("rst_pulse", 32'(press_pulse), 0);
    chk("rst_count", 32'(press_count), 0);
    chk("rst_state", 32'(state_dbg), 0);

    // Button held through reset release is not a press
    rst_n = 1'b1;
    repeat (10) tick();
    chk("held_walk_req", 32'(walk_req), 0);
    chk("held_count", 32'(press_count), 0);
    chk("held_state", 32'(state_dbg), 0);

    // Fresh press from IDLE
    btn = 1'b0; tick();
    btn = 1'b1; tick();
    chk("p1_walk_req", 32'(walk_req), 1);
    chk("p1_pending", 32'(pending), 1);
    chk("p1_pulse", 32'(press_pulse), 1);
    chk("p1_count", 32'(press_count), 1);
    chk("p1_state", 32'(state_dbg), 1);
    btn = 1'b0; tick();
    chk("p1_pulse_end", 32'(press_pulse), 0);
    chk("p1_req_hold", 32'(walk_req), 1);

    // Press in REQ is ignored
    btn = 1'b1; tick();
    chk("req_press_pulse", 32'(press_pulse), 0);
    chk("req_press_count", 32'(press_count), 1);
    btn = 1'b0; tick();

    // Grant moves to SERVE
    walk_ack = 1'b1; tick(); walk_ack = 1'b0;
    chk("ack_state", 32'(state_dbg), 2);
    chk("ack_walk_req", 32'(walk_req), 0);
    chk("ack_pending", 32'(pending), 0);

    // Press in SERVE is ignored
    btn = 1'b1; tick();
    chk("serve_press_pulse", 32'(press_pulse), 0);
    chk("serve_press_count", 32'(press_count), 1);
    btn = 1'b0; tick();

    // Lockout lasts exactly LOCKOUT_CYCLES
    walk_done = 1'b1; tick(); walk_done = 1'b0;
    chk("lck_state", 32'(state_dbg), 3);
    for (int i = 0; i < 4; i++) begin
      chk("lck_active", 32'(lockout), 1);
      chk("lck_no_pending", 32'(pending), 0);
      tick();
    end
    chk("lck_end_flag", 32'(lockout), 0);
    chk("lck_end_state", 32'(state_dbg), 0);

    // Simultaneous ack and done in REQ goes to SERVE only
    btn = 1'b1; tick(); btn = 1'b0;
    chk("p2_count", 32'(press_count), 2);
    walk_ack = 1'b1; walk_done = 1'b1; tick();
    walk_ack = 1'b0; walk_done = 1'b0;
    chk("ackdone_state", 32'(state_dbg), 2);
    chk("ackdone_lockout", 32'(lockout), 0);

    // Press early in lockout is deferred
    walk_done = 1'b1; tick(); walk_done = 1'b0;
    btn = 1'b1; tick();
    chk("def_pending", 32'(pending), 1);
    chk("def_pulse", 32'(press_pulse), 1);
    chk("def_count", 32'(press_count), 3);
    chk("def_lockout", 32'(lockout), 1);
    btn = 1'b0; tick();
    tick();
    chk("def_still_lck", 32'(state_dbg), 3);
    tick();
    chk("def_exp_state", 32'(state_dbg), 1);
    chk("def_exp_walk_req", 32'(walk_req), 1);
    chk("def_exp_lockout", 32'(lockout), 0);

    // Press on final lockout cycle
    walk_ack = 1'b1; tick(); walk_ack = 1'b0;
    walk_done = 1'b1; tick(); walk_done = 1'b0;
    tick(); tick(); tick();
    chk("fin_pre_state", 32'(state_dbg), 3);
    btn = 1'b1; tick(); btn = 1'b0;
    chk("fin_state", 32'(state_dbg), 1);
    chk("fin_walk_req", 32'(walk_req), 1);
    chk("fin_pending", 32'(pending), 1);
    chk("fin_pulse", 32'(press_pulse), 1);
    chk("fin_count", 32'(press_count), 4);

    // Quiet lockout returns to IDLE: no stale deferred request
    walk_ack = 1'b1; tick(); walk_ack = 1'b0;
    walk_done = 1'b1; tick(); walk_done = 1'b0;
    repeat (4) tick();
    chk("quiet_state", 32'(state_dbg), 0);
    chk("quiet_pending", 32'(pending), 0);

    // Ack/done in IDLE have no effect
    walk_ack = 1'b1; walk_done = 1'b1; tick();
    walk_ack = 1'b0; walk_done = 1'b0;
    chk("idle_hs_state", 32'(state_dbg), 0);

    // Saturation of the press counter at 7
    btn = 1'b1; tick(); btn = 1'b0;
    chk("sat_c5", 32'(press_count), 5);
    walk_ack = 1'b1; tick(); walk_ack = 1'b0;
    walk_done = 1'b1; tick(); walk_done = 1'b0;
    btn = 1'b1; tick(); btn = 1'b0; tick();
    btn = 1'b1; tick(); btn = 1'b0;
    chk("sat_c7", 32'(press_count), 7);
    tick();
    chk("sat_req1", 32'(state_dbg), 1);
    walk_ack = 1'b1; tick(); walk_ack = 1'b0;
    walk_done = 1'b1; tick(); walk_done = 1'b0;
    btn = 1'b1; tick(); btn = 1'b0;
    chk("sat_pulse8", 32'(press_pulse), 1);
    chk("sat_c8", 32'(press_count), 7);
    tick();
    btn = 1'b1; tick(); btn = 1'b0;
    chk("sat_pulse9", 32'(press_pulse), 1);
    chk("sat_c9", 32'(press_count), 7);
    tick();
    chk("sat_req2", 32'(state_dbg), 1);

    // Asynchronous reset mid-lockout with a deferred request
    walk_ack = 1'b1; tick(); walk_ack = 1'b0;
    walk_done = 1'b1; tick(); walk_done = 1'b0;
    btn = 1'b1; tick(); btn = 1'b0;
    chk("arst_pre_pending", 32'(pending), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_walk_req", 32'(walk_req), 0);
    chk("arst_pending", 32'(pending), 0);
    chk("arst_lockout", 32'(lockout), 0);
    chk("arst_pulse", 32'(press_pulse), 0);
    chk("arst_count", 32'(press_count), 0);
    chk("arst_state", 32'(state_dbg), 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
